dual_port_ram_pipelined: RTL and testbench



---
 rtl/dual_port_ram_pipelined.sv | 162 ++++++++++++++++
 tb/tb_dual_port_ram_pipelined.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : dual_port_ram_pipelined
// Brief    : Simple-dual-port byte-enabled RAM. It has a 1..4 stage read pipeline
//            and an optional zero-fill after reset. Define
//            DUAL_PORT_RAM_PIPELINED_BYPASS_EN for new-data collision behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module dual_port_ram_pipelined #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 1024,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 2,
    parameter int CLEAR_ON_RESET = 1,
    localparam int c_addr_w      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int c_lanes       = WIDTH / BYTE_WIDTH
) (
    input  logic                ipClk,
    input  logic                ipReset,
    input  logic [c_addr_w-1:0] ipWrAddress,
    input  logic [WIDTH-1:0]    ipWrData,
    input  logic [c_lanes-1:0]  ipWrByteEnable,
    input  logic                ipWrEnable,
    input  logic [c_addr_w-1:0] ipRdAddress,
    input  logic                ipRdEnable,
    output logic [WIDTH-1:0]    opRdData,
    output logic                opRdValid,
    output logic                opReady
);

    localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_ready;
    logic [c_addr_w-1:0]   r_clr_cnt;
    logic [WIDTH-1:0]      r_mem [0:DEPTH-1];
    logic [READ_LATENCY-1:0] r_vld;
    logic [WIDTH-1:0]      r_data [0:READ_LATENCY-1];

    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic                  w_clr_we;
    logic                  w_mem_we;
    logic [c_addr_w-1:0]   w_mem_addr;
    logic [WIDTH-1:0]      w_mem_data;
    logic [c_lanes-1:0]    w_mem_be;
    logic [WIDTH-1:0]      w_rd_stored;
    logic [WIDTH-1:0]      w_rd_word;

    // Range checks vanish when the depth fills the whole address space.
    generate
        if (DEPTH == (1 << c_addr_w)) begin : g_full_range
            assign w_wr_in_range = 1'b1;
            assign w_rd_in_range = 1'b1;
        end else begin : g_partial_range
            assign w_wr_in_range = (ipWrAddress <= c_last_addr);
            assign w_rd_in_range = (ipRdAddress <= c_last_addr);
        end
    endgenerate

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            r_ready   <= 1'b0;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == c_last_addr) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign w_clr_we    = (r_state == ST_CLEAR) && !ipReset;
    assign w_wr_accept = ipWrEnable && r_ready && !ipReset;
    assign w_rd_accept = ipRdEnable && r_ready && !ipReset;

    // The fill and user writes share the single write port; they never overlap.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = ipWrAddress;
        w_mem_data = ipWrData;
        w_mem_be   = ipWrByteEnable;
        if (w_clr_we) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_clr_cnt;
            w_mem_data = '0;
            w_mem_be   = '1;
        end else if (w_wr_accept && w_wr_in_range) begin
            w_mem_we   = 1'b1;
        end
    end

    always_ff @(posedge ipClk) begin
        if (w_mem_we) begin
            for (int i = 0; i < c_lanes; i++) begin
                if (w_mem_be[i]) begin
                    r_mem[w_mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_mem_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign w_rd_stored = w_rd_in_range ? r_mem[ipRdAddress] : '0;

`ifdef DUAL_PORT_RAM_PIPELINED_BYPASS_EN
    always_comb begin
        w_rd_word = w_rd_stored;
        if (w_wr_accept && w_rd_in_range && (ipWrAddress == ipRdAddress)) begin
            for (int i = 0; i < c_lanes; i++) begin
                if (ipWrByteEnable[i]) begin
                    w_rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = ipWrData[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end
`else
    assign w_rd_word = w_rd_stored;
`endif

    // Data stages only load behind a valid, so the output holds between strobes.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            r_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd_accept;
            if (w_rd_accept) begin
                r_data[0] <= w_rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign opRdData  = r_data[READ_LATENCY-1];
    assign opRdValid = r_vld[READ_LATENCY-1];
    assign opReady   = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_port_ram_pipelined
// Brief    : Scoreboard bench over three RAM configurations (A: clear-on-reset,
//            B: byte merge / out-of-range, C: mid-flight reset / retention).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_port_ram_pipelined;

    localparam int N = 3;

    typedef struct packed {
        int          d;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic [N-1:0]          rst;
    logic [N-1:0][3:0]     wa;
    logic [N-1:0][31:0]    wd;
    logic [N-1:0][3:0]     be;
    logic [N-1:0]          we;
    logic [N-1:0][3:0]     ra;
    logic [N-1:0]          re;
    logic [N-1:0][31:0]    rd;
    logic [N-1:0]          rv;
    logic [N-1:0]          rdy;

    logic [N-1:0]          acc;
    logic [N-1:0]          prev_rst = '1;
    logic [31:0]           last [N];
    logic [31:0]           model [N][16];
    exp_t                  q[$];
    exp_t                  m_e;
    int                    m_idx;
    int                    cyc = 0;
    int                    checks = 0;
    int                    errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dual_port_ram_pipelined #(.WIDTH(32), .DEPTH(16), .BYTE_WIDTH(8), .READ_LATENCY(3), .CLEAR_ON_RESET(1)) u_dut_a (
        .ipClk(clk), .ipReset(rst[0]), .ipWrAddress(wa[0]), .ipWrData(wd[0]), .ipWrByteEnable(be[0]),
        .ipWrEnable(we[0]), .ipRdAddress(ra[0]), .ipRdEnable(re[0]), .opRdData(rd[0]),
        .opRdValid(rv[0]), .opReady(rdy[0]));

    dual_port_ram_pipelined #(.WIDTH(32), .DEPTH(12), .BYTE_WIDTH(8), .READ_LATENCY(2), .CLEAR_ON_RESET(0)) u_dut_b (
        .ipClk(clk), .ipReset(rst[1]), .ipWrAddress(wa[1]), .ipWrData(wd[1]), .ipWrByteEnable(be[1]),
        .ipWrEnable(we[1]), .ipRdAddress(ra[1]), .ipRdEnable(re[1]), .opRdData(rd[1]),
        .opRdValid(rv[1]), .opReady(rdy[1]));

    dual_port_ram_pipelined #(.WIDTH(32), .DEPTH(12), .BYTE_WIDTH(8), .READ_LATENCY(4), .CLEAR_ON_RESET(0)) u_dut_c (
        .ipClk(clk), .ipReset(rst[2]), .ipWrAddress(wa[2]), .ipWrData(wd[2]), .ipWrByteEnable(be[2]),
        .ipWrEnable(we[2]), .ipRdAddress(ra[2]), .ipRdEnable(re[2]), .opRdData(rd[2]),
        .opRdValid(rv[2]), .opReady(rdy[2]));

    function automatic int depth_of(int d);
        return (d == 0) ? 16 : 12;
    endfunction

    function automatic int rl_of(int d);
        return (d == 0) ? 3 : ((d == 1) ? 2 : 4);
    endfunction

    task automatic chk1(string tag, logic obs, logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk32(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    // Predict the read result and update the model for every accepted request.
    task automatic step();
        for (int d = 0; d < N; d++) begin
            if (acc[d] && re[d]) begin
                exp_t        e;
                logic [31:0] v;
                v = (int'(ra[d]) < depth_of(d)) ? model[d][ra[d]] : 32'h0;
`ifdef DUAL_PORT_RAM_PIPELINED_BYPASS_EN
                if (we[d] && wa[d] == ra[d] && int'(ra[d]) < depth_of(d))
                    for (int b = 0; b < 4; b++)
                        if (be[d][b]) v[b*8 +: 8] = wd[d][b*8 +: 8];
`endif
                e.d = d; e.data = v; e.cyc = cyc + rl_of(d);
                q.push_back(e);
            end
            if (acc[d] && we[d] && int'(wa[d]) < depth_of(d))
                for (int b = 0; b < 4; b++)
                    if (be[d][b]) model[d][wa[d]][b*8 +: 8] = wd[d][b*8 +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int d, logic [3:0] a, logic [31:0] data, logic [3:0] b);
        we[d] = 1'b1; wa[d] = a; wd[d] = data; be[d] = b;
    endtask

    task automatic rdq(int d, logic [3:0] a);
        re[d] = 1'b1; ra[d] = a;
    endtask

    task automatic idle();
        we = '0; re = '0;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < N; d++) begin
            if (prev_rst[d]) last[d] = 32'h0;
            if (rv[d] === 1'b1) begin
                m_idx = -1;
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].d == d) begin
                        m_idx = i;
                        break;
                    end
                end
                checks++;
                assert (m_idx >= 0) else begin
                    errors++;
                    $error("FAIL unexpected_valid dut%0d cyc %0d: observed valid with data %h, expected no valid", d, cyc, rd[d]);
                end
                if (m_idx >= 0) begin
                    m_e = q[m_idx];
                    q.delete(m_idx);
                    checks++;
                    assert (cyc == m_e.cyc) else begin
                        errors++;
                        $error("FAIL valid_cycle dut%0d: observed cycle %0d, expected %0d", d, cyc, m_e.cyc);
                    end
                    checks++;
                    assert (rd[d] === m_e.data) else begin
                        errors++;
                        $error("FAIL rd_data dut%0d cyc %0d: observed %h, expected %h", d, cyc, rd[d], m_e.data);
                    end
                    last[d] = m_e.data;
                end
            end else begin
                checks++;
                assert (rd[d] === last[d]) else begin
                    errors++;
                    $error("FAIL rd_hold dut%0d cyc %0d: observed %h, expected %h", d, cyc, rd[d], last[d]);
                end
            end
            prev_rst[d] = rst[d];
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        rst = '1; acc = '0; we = '0; re = '0;
        wa = '0; wd = '0; be = '0; ra = '0;
        for (int d = 0; d < N; d++)
            for (int a = 0; a < 16; a++) model[d][a] = 32'h0;
        repeat (3) step();
        for (int d = 0; d < N; d++) begin
            chk1($sformatf("reset_ready_dut%0d", d), rdy[d], 1'b0);
            chk1($sformatf("reset_valid_dut%0d", d), rv[d], 1'b0);
            chk32($sformatf("reset_data_dut%0d", d), rd[d], 32'h0);
        end

        // Release all resets; A fills 16 words, B and C are ready after one cycle.
        rst = '0;
        for (int i = 0; i < 32; i++) begin
            chk1($sformatf("ready_a_i%0d", i), rdy[0], i >= 16);
            chk1($sformatf("ready_b_i%0d", i), rdy[1], i >= 1);
            chk1($sformatf("ready_c_i%0d", i), rdy[2], i >= 1);
            acc[0] = (i >= 16); acc[1] = (i >= 1); acc[2] = (i >= 1);
            rdq(0, 4'(i));
            step();
        end
        idle();
        step();

        // A: streaming writes then back-to-back reads.
        for (int a = 0; a < 8; a++) begin
            wr(0, 4'(a), 32'(a * 3), 4'hF);
            step();
        end
        idle();
        for (int a = 0; a < 8; a++) begin
            rdq(0, 4'(a));
            step();
        end
        idle();

        // A: collision on address 9, then a read the cycle after the write.
        wr(0, 4'd9, 32'hFFFF_FFFF, 4'b0011);
        rdq(0, 4'd9);
        step();
        idle();
        rdq(0, 4'd9);
        step();
        // A: a later write must not disturb an in-flight read of the same word.
        idle();
        rdq(0, 4'd3);
        step();
        idle();
        wr(0, 4'd3, 32'h0000_0055, 4'hF);
        step();
        idle();
        step();

        // B: byte-lane merge, then out-of-range write/read.
        wr(1, 4'd5, 32'hAABB_CCDD, 4'b1111);
        step();
        wr(1, 4'd5, 32'h1122_3344, 4'b0101);
        step();
        idle();
        rdq(1, 4'd5);
        step();
        idle();
        wr(1, 4'd13, 32'hDEAD_BEEF, 4'hF);
        step();
        idle();
        rdq(1, 4'd13);
        step();
        rdq(1, 4'd5);
        step();
        idle();

        // C: preload, launch three reads, reset before any of them returns.
        wr(2, 4'd2, 32'hCAFE_F00D, 4'hF);
        step();
        wr(2, 4'd11, 32'h1234_5678, 4'hF);
        step();
        idle();
        acc[2] = 1'b0;
        rdq(2, 4'd2);  step();
        rdq(2, 4'd11); step();
        rdq(2, 4'd2);  step();
        idle();
        rst[2] = 1'b1;
        step();
        step();
        rst[2] = 1'b0;
        chk1("ready_c_after_reset_r", rdy[2], 1'b0);
        chk1("valid_c_after_reset_r", rv[2], 1'b0);
        step();
        chk1("ready_c_after_reset_r1", rdy[2], 1'b1);
        for (int k = 0; k < 4; k++) chk1($sformatf("no_valid_c_k%0d", k), rv[2], 1'b0);
        acc[2] = 1'b1;
        rdq(2, 4'd2);
        step();
        rdq(2, 4'd11);
        step();
        idle();

        for (int k = 0; k < 20 && q.size() != 0; k++) step();
        chk32("scoreboard_drained", 32'(q.size()), 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
